// File: rtl/mod_counter_if.sv
// rtl/mod_counter_if.sv - control and status bundle for mod_counter
interface mod_counter_if #(
  parameter int WIDTH = 6
) ();
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_reg;
  logic             up_dn;
  logic [WIDTH-1:0] cnt;
  logic             carry;
  logic             borrow;
  logic             sat;
  logic             load_err;
  logic             tc;

  modport master (
    output en, load, load_reg, up_dn,
    input  cnt, carry, borrow, sat, load_err, tc
  );

  modport slave (
    input  en, load, load_reg, up_dn,
    output cnt, carry, borrow, sat, load_err, tc
  );
endinterface

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - prescaled up/down modulo counter with wrap or saturate ends
// Load beats step; the prescaler phase only advances on enabled, non-load cycles.
module mod_counter #(
  parameter int WIDTH    = 6,
  parameter int MODULUS  = 60,
  parameter int PRESCALE = 1,
  parameter int WRAP     = 1
) (
  input  logic         clk,
  input  logic         rst,
  mod_counter_if.slave bus
);
  localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);
  localparam logic [PW-1:0]    PSC_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    psc_q, psc_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             sat_q, sat_d;
  logic             lerr_q, lerr_d;
  logic             step, at_max, at_zero;

  assign step    = bus.en && (psc_q == PSC_LAST);
  assign at_max  = (cnt_q == MAX_CNT);
  assign at_zero = (cnt_q == '0);

  always_comb begin
    cnt_d    = cnt_q;
    psc_d    = psc_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    sat_d    = sat_q;
    lerr_d   = 1'b0;
    if (bus.load) begin
      psc_d = '0;
      sat_d = 1'b0;
      // Out-of-range loads clamp to the top of the range rather than truncating.
      if ({1'b0, bus.load_reg} < MOD_EXT) begin
        cnt_d = bus.load_reg;
      end else begin
        cnt_d  = MAX_CNT;
        lerr_d = 1'b1;
      end
    end else if (bus.en) begin
      psc_d = step ? '0 : psc_q + PW'(1);
      if (step) begin
        if (bus.up_dn) begin
          if (!at_max) begin
            cnt_d = cnt_q + WIDTH'(1);
            sat_d = 1'b0;
          end else if (WRAP != 0) begin
            cnt_d   = '0;
            carry_d = 1'b1;
            sat_d   = 1'b0;
          end else begin
            sat_d = 1'b1;
          end
        end else begin
          if (!at_zero) begin
            cnt_d = cnt_q - WIDTH'(1);
            sat_d = 1'b0;
          end else if (WRAP != 0) begin
            cnt_d    = MAX_CNT;
            borrow_d = 1'b1;
            sat_d    = 1'b0;
          end else begin
            sat_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      psc_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      sat_q    <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      psc_q    <= psc_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      sat_q    <= sat_d;
      lerr_q   <= lerr_d;
    end
  end

  assign bus.cnt      = cnt_q;
  assign bus.carry    = carry_q;
  assign bus.borrow   = borrow_q;
  assign bus.sat      = sat_q;
  assign bus.load_err = lerr_q;
  assign bus.tc       = bus.up_dn ? at_max : at_zero;
endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - scoreboard bench driving three counter configurations in lockstep
module tb_mod_counter;
  localparam int NCFG = 3;
  localparam int MODV [NCFG] = '{60, 10, 8};
  localparam int PREV [NCFG] = '{1, 4, 3};
  localparam int WIDV [NCFG] = '{6, 4, 3};
  localparam int WRPV [NCFG] = '{1, 0, 1};

  typedef struct packed {
    logic [NCFG-1:0][5:0] cnt;
    logic [NCFG-1:0]      carry;
    logic [NCFG-1:0]      borrow;
    logic [NCFG-1:0]      sat;
    logic [NCFG-1:0]      lerr;
    logic [NCFG-1:0]      tc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];

  int m_cnt [NCFG];
  int m_ph  [NCFG];
  int m_sat [NCFG];

  mod_counter_if #(.WIDTH(6)) if0 ();
  mod_counter_if #(.WIDTH(4)) if1 ();
  mod_counter_if #(.WIDTH(3)) if2 ();

  mod_counter #(.WIDTH(6), .MODULUS(60), .PRESCALE(1), .WRAP(1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(4), .WRAP(0)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  mod_counter #(.WIDTH(3), .MODULUS(8),  .PRESCALE(3), .WRAP(1)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  always #5 clk = ~clk;

  task automatic chk(string nm, int k, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cfg%0d got %0d expected %0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic int act_cnt(int k);
    case (k)
      0:       return int'(if0.cnt);
      1:       return int'(if1.cnt);
      default: return int'(if2.cnt);
    endcase
  endfunction

  function automatic logic [4:0] act_flags(int k);
    case (k)
      0:       return {if0.carry, if0.borrow, if0.sat, if0.load_err, if0.tc};
      1:       return {if1.carry, if1.borrow, if1.sat, if1.load_err, if1.tc};
      default: return {if2.carry, if2.borrow, if2.sat, if2.load_err, if2.tc};
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCFG; k++) begin
      m_cnt[k] = 0;
      m_ph[k]  = 0;
      m_sat[k] = 0;
    end
  endtask

  task automatic check_reset_state(string nm);
    for (int k = 0; k < NCFG; k++) begin
      logic [4:0] f;
      f = act_flags(k);
      chk({nm, "_cnt"}, k, act_cnt(k), 0);
      chk({nm, "_flags"}, k, int'(f[4:1]), 0);
    end
  endtask

  task automatic cycle(bit e, bit l, int lv, bit u, bit do_rst);
    exp_t x;
    @(negedge clk);
    if (do_rst) begin
      #1 rst = 1'b1;
      #1 check_reset_state("async_rst");
      rst = 1'b0;
      model_reset();
    end
    if0.en = e; if1.en = e; if2.en = e;
    if0.load = l; if1.load = l; if2.load = l;
    if0.up_dn = u; if1.up_dn = u; if2.up_dn = u;
    if0.load_reg = 6'(lv); if1.load_reg = 4'(lv); if2.load_reg = 3'(lv);
    x = '0;
    for (int k = 0; k < NCFG; k++) begin
      int m;
      int v;
      m = MODV[k];
      v = lv % (1 << WIDV[k]);
      if (l) begin
        m_ph[k]  = 0;
        m_sat[k] = 0;
        if (v < m) m_cnt[k] = v;
        else begin
          m_cnt[k] = m - 1;
          x.lerr[k] = 1'b1;
        end
      end else if (e) begin
        m_ph[k]++;
        if (m_ph[k] == PREV[k]) begin
          m_ph[k] = 0;
          if (u) begin
            if (m_cnt[k] + 1 < m) begin
              m_cnt[k]++;
              m_sat[k] = 0;
            end else if (WRPV[k] != 0) begin
              m_cnt[k] = 0;
              x.carry[k] = 1'b1;
              m_sat[k] = 0;
            end else m_sat[k] = 1;
          end else begin
            if (m_cnt[k] > 0) begin
              m_cnt[k]--;
              m_sat[k] = 0;
            end else if (WRPV[k] != 0) begin
              m_cnt[k] = m - 1;
              x.borrow[k] = 1'b1;
              m_sat[k] = 0;
            end else m_sat[k] = 1;
          end
        end
      end
      x.cnt[k] = 6'(m_cnt[k]);
      x.sat[k] = m_sat[k][0];
      x.tc[k]  = u ? (m_cnt[k] == m - 1) : (m_cnt[k] == 0);
    end
    sb_q.push_back(x);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sb_q.size() > 0) begin
        exp_t x;
        x = sb_q.pop_front();
        for (int k = 0; k < NCFG; k++) begin
          logic [4:0] f;
          f = act_flags(k);
          chk("cnt", k, act_cnt(k), int'(x.cnt[k]));
          chk("carry", k, int'(f[4]), int'(x.carry[k]));
          chk("borrow", k, int'(f[3]), int'(x.borrow[k]));
          chk("sat", k, int'(f[2]), int'(x.sat[k]));
          chk("load_err", k, int'(f[1]), int'(x.lerr[k]));
          chk("tc", k, int'(f[0]), int'(x.tc[k]));
        end
      end
    end
  end

  initial begin
    bit u;
    if0.en = 0; if1.en = 0; if2.en = 0;
    if0.load = 0; if1.load = 0; if2.load = 0;
    if0.up_dn = 1; if1.up_dn = 1; if2.up_dn = 1;
    if0.load_reg = '0; if1.load_reg = '0; if2.load_reg = '0;
    model_reset();
    #1 check_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 62; i++) cycle(1, 0, 0, 1, 0);
    cycle(1, 1, 63, 1, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 8, 1, 0);
    for (int i = 0; i < 12; i++) cycle(1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 1, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 1, 0);
    cycle(1, 1, 37, 1, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 1, 0);

    u = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 29) == 0) u = ~u;
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0,
            int'($urandom_range(0, 63)), u, $urandom_range(0, 199) == 0);
    end

    @(posedge clk);
    #3;
    chk("scoreboard_drained", 0, sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
